// File: rtl/capture_pkg.sv
// capture_pkg: shared opcodes, sequencer state encoding and argument byte-swap helper
// Imported by capture_controller and capture_sequencer.
package capture_pkg;
  localparam logic [7:0] OP_RESET = 8'h00;
  localparam logic [7:0] OP_ARM   = 8'h01;
  localparam logic [7:0] OP_ID    = 8'h02;
  localparam logic [7:0] OP_TMASK = 8'hC0;
  localparam logic [7:0] OP_TVAL  = 8'hC1;
  localparam logic [7:0] OP_TCFG  = 8'hC2;
  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_CNT   = 8'h81;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_POST    = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_READOUT = 3'd4
  } state_t;
  // The first received byte sits in command[31:24] but is the argument LSB.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/capture_sequencer.sv
// capture_sequencer: capture FSM (arm, trigger wait, post-trigger count, readout handshake)
// Ports:
//   clock, reset        clock, async active-high reset
//   arm_i               accepted arm command (only asserted in IDLE)
//   flush_i             soft reset command; forces IDLE, beats every other event
//   trig_start_i        1: wait in ARMED for trigger, 0: go straight to POST
//   delay_count_i       post-trigger sample count loaded on POST entry
//   sample_tick_i       one pulse per sample period
//   trigger_hit_i       trigger match level
//   readout_done_i      readout engine completion pulse
//   state_o             current state
//   capture_en_o        high in ARMED and POST
//   readout_start_o     registered one-cycle pulse coinciding with RD_REQ
//   busy_o              state != IDLE
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             arm_i,
  input  logic             flush_i,
  input  logic             trig_start_i,
  input  logic [CNT_W-1:0] delay_count_i,
  input  logic             sample_tick_i,
  input  logic             trigger_hit_i,
  input  logic             readout_done_i,
  output state_t           state_o,
  output logic             capture_en_o,
  output logic             readout_start_o,
  output logic             busy_o
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             readout_start_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (arm_i) begin
          state_d = trig_start_i ? ST_ARMED : ST_POST;
          cnt_d   = delay_count_i;
        end
        ST_ARMED: if (trigger_hit_i) begin
          state_d = ST_POST;
          cnt_d   = delay_count_i;
        end
        // Count is checked before ticks, so a zero delay still spends one cycle in POST.
        ST_POST: if (cnt_q == '0) state_d = ST_RD_REQ;
                 else if (sample_tick_i) cnt_d = cnt_q - CNT_W'(1);
        ST_RD_REQ:  state_d = ST_READOUT;
        ST_READOUT: if (readout_done_i) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      readout_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      readout_start_q <= state_d == ST_RD_REQ;
    end
  end
  assign state_o         = state_q;
  assign capture_en_o    = state_q == ST_ARMED || state_q == ST_POST;
  assign readout_start_o = readout_start_q;
  assign busy_o          = state_q != ST_IDLE;
endmodule

// File: rtl/capture_controller.sv
// capture_controller: command decode, analyzer config registers and capture sequencing
// Optional feature macro: CAPTURE_CTRL_STATS_EN (saturating ignored-command counter).
// Ports:
//   clock, reset                 clock, async active-high reset
//   cmd_valid, opcode, command   decoded command pulse, opcode and raw 32-bit argument
//   sample_tick, trigger_hit     sampler tick and trigger match from the datapath
//   readout_done                 readout engine completion pulse
//   trig_mask, trig_value        trigger configuration
//   trig_start                   trigger enable (0: capture starts on arm)
//   divider, read_count, delay_count  sampler / readout configuration
//   capture_en, readout_start    sampler write enable, readout request pulse
//   id_req, soft_reset           one-cycle ID request and datapath clear pulses
//   busy, state_o                sequencer status
//   ignored_cnt                  ignored-command counter (0 when stats disabled)
module capture_controller
  import capture_pkg::*;
#(
  parameter int DIV_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [7:0]       opcode,
  input  logic [31:0]      command,
  input  logic             sample_tick,
  input  logic             trigger_hit,
  input  logic             readout_done,
  output logic [31:0]      trig_mask,
  output logic [31:0]      trig_value,
  output logic             trig_start,
  output logic [DIV_W-1:0] divider,
  output logic [CNT_W-1:0] read_count,
  output logic [CNT_W-1:0] delay_count,
  output logic             capture_en,
  output logic             readout_start,
  output logic             id_req,
  output logic             soft_reset,
  output logic             busy,
  output logic [2:0]       state_o,
  output logic [7:0]       ignored_cnt
);
  logic [31:0]      arg;
  state_t           state;
  logic             known, accept, rst_cmd;
  logic [31:0]      trig_mask_q, trig_mask_d, trig_value_q, trig_value_d;
  logic             trig_start_q, trig_start_d;
  logic [DIV_W-1:0] divider_q, divider_d;
  logic [CNT_W-1:0] read_count_q, read_count_d, delay_count_q, delay_count_d;
  logic             id_req_q, soft_reset_q;
  assign arg     = byte_swap32(command);
  assign known   = opcode inside {OP_ARM, OP_ID, OP_TMASK, OP_TVAL, OP_TCFG, OP_DIV, OP_CNT};
  assign rst_cmd = cmd_valid && opcode == OP_RESET;
  // Acceptance uses the pre-transition state, so a command racing a sequencer transition sees the old state.
  assign accept  = cmd_valid && known && state == ST_IDLE;
  always_comb begin
    trig_mask_d   = accept && opcode == OP_TMASK ? arg : trig_mask_q;
    trig_value_d  = accept && opcode == OP_TVAL ? arg : trig_value_q;
    trig_start_d  = accept && opcode == OP_TCFG ? arg[27] : trig_start_q;
    divider_d     = accept && opcode == OP_DIV ? arg[DIV_W-1:0] : divider_q;
    read_count_d  = accept && opcode == OP_CNT ? arg[CNT_W-1:0] : read_count_q;
    delay_count_d = accept && opcode == OP_CNT ? arg[CNT_W+15:16] : delay_count_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_mask_q   <= '0;
      trig_value_q  <= '0;
      trig_start_q  <= 1'b0;
      divider_q     <= '0;
      read_count_q  <= '0;
      delay_count_q <= '0;
      id_req_q      <= 1'b0;
      soft_reset_q  <= 1'b0;
    end else begin
      trig_mask_q   <= trig_mask_d;
      trig_value_q  <= trig_value_d;
      trig_start_q  <= trig_start_d;
      divider_q     <= divider_d;
      read_count_q  <= read_count_d;
      delay_count_q <= delay_count_d;
      id_req_q      <= accept && opcode == OP_ID;
      soft_reset_q  <= rst_cmd;
    end
  end
  capture_sequencer #(.CNT_W(CNT_W)) u_seq (
    .clock          (clock),
    .reset          (reset),
    .arm_i          (accept && opcode == OP_ARM),
    .flush_i        (rst_cmd),
    .trig_start_i   (trig_start_q),
    .delay_count_i  (delay_count_q),
    .sample_tick_i  (sample_tick),
    .trigger_hit_i  (trigger_hit),
    .readout_done_i (readout_done),
    .state_o        (state),
    .capture_en_o   (capture_en),
    .readout_start_o(readout_start),
    .busy_o         (busy)
  );
`ifdef CAPTURE_CTRL_STATS_EN
  logic [7:0] ign_q, ign_d;
  logic       ignore;
  assign ignore = cmd_valid && opcode != OP_RESET && !accept;
  always_comb ign_d = rst_cmd ? 8'd0 : (ignore && ign_q != 8'hFF) ? ign_q + 8'd1 : ign_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ign_q <= '0;
    else ign_q <= ign_d;
  end
  assign ignored_cnt = ign_q;
`else
  assign ignored_cnt = '0;
`endif
  assign trig_mask   = trig_mask_q;
  assign trig_value  = trig_value_q;
  assign trig_start  = trig_start_q;
  assign divider     = divider_q;
  assign read_count  = read_count_q;
  assign delay_count = delay_count_q;
  assign id_req      = id_req_q;
  assign soft_reset  = soft_reset_q;
  assign state_o     = state;
endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
- Consumes decoded 5-byte commands (opcode plus 32-bit argument) from the command decoder and holds the analyzer configuration registers: trigger mask/value, trigger enable, sample divider, read and delay counts.
- Sequences a capture: arm, wait for trigger, count post-trigger samples, request readout, return to idle.
- Sits between the command decoder and the sampler / trigger / readout datapath.

Parameters:
- DIV_W, 24, width of sample divider register
- CNT_W, 16, width of read_count and delay_count

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  single-cycle pulse; opcode/command valid
- opcode  in  8  command opcode
- command  in  32  argument; command[31:24] is the first byte received
- sample_tick  in  1  one pulse per divided sample period
- trigger_hit  in  1  trigger unit match (level)
- readout_done  in  1  pulse from readout engine when transfer is complete
- trig_mask  out  32  trigger mask register
- trig_value  out  32  trigger value register
- trig_start  out  1  trigger enable; 0 means capture starts immediately on arm
- divider  out  DIV_W  sample divider
- read_count  out  CNT_W  samples to read out
- delay_count  out  CNT_W  post-trigger samples
- capture_en  out  1  sampler writes memory while high
- readout_start  out  1  one-cycle readout request
- id_req  out  1  one-cycle request to transmit device ID
- soft_reset  out  1  one-cycle datapath clear
- busy  out  1  state != IDLE
- state_o  out  3  current state encoding, for debug
- ignored_cnt  out  8  ignored-command counter (see Optional Feature)

Behaviour:
- Argument byte order: arg = {command[7:0], command[15:8], command[23:16], command[31:24]}. The first received byte is the LSB.
- Reset values: trig_mask = 0, trig_value = 0, trig_start = 0, divider = 0, read_count = 0, delay_count = 0. All pulse and level outputs are 0, state = IDLE.
- Register writes take effect the cycle after cmd_valid. Writes are accepted only in IDLE; otherwise the command is ignored.
- Opcodes:
  - 0x00: soft reset, accepted in any state. Pulses soft_reset, forces IDLE, clears capture_en. Config registers are kept.
  - 0x01: arm. If trig_start = 1, go IDLE->ARMED; else go IDLE->POST.
  - 0x02: pulse id_req (IDLE only).
  - 0xC0: trig_mask <= arg.
  - 0xC1: trig_value <= arg.
  - 0xC2: trig_start <= arg[27].
  - 0x80: divider <= arg[DIV_W-1:0].
  - 0x81: read_count <= arg[CNT_W-1:0]; delay_count <= arg[CNT_W+15:16].
  - Any other opcode: ignored, no side effect.
- States (state_o encoding): IDLE = 0, ARMED = 1, POST = 2, RD_REQ = 3, READOUT = 4.
  - ARMED: when trigger_hit = 1, go to POST and load cnt <= delay_count. The tick on the trigger cycle is not counted.
  - POST: cnt decrements on each sample_tick. When cnt == 0, go to RD_REQ on the next cycle. delay_count = 0 gives POST for exactly 1 cycle.
  - Entry to POST directly from arm also loads cnt <= delay_count.
  - RD_REQ: readout_start = 1 for one cycle, then READOUT.
  - READOUT: readout_done -> IDLE.
- capture_en = 1 in ARMED and POST.
- Pulse timing: id_req, soft_reset and readout_start are registered, asserted exactly 1 cycle, starting 1 cycle after their cause.
- Simultaneous events:
  - Soft reset beats trigger_hit, tick and readout_done.
  - readout_done outside READOUT is ignored.
  - cmd_valid on the same cycle as an FSM transition is evaluated against the pre-transition state.
- Async reset mid-capture returns everything to reset values immediately.

Optional Feature:
- Macro: CAPTURE_CTRL_STATS_EN.
- Defined: ignored_cnt is an 8-bit saturating counter (stops at 255). It increments on each cmd_valid with an unknown opcode, or with a config/arm/ID opcode arriving outside IDLE. It is cleared by reset and by opcode 0x00.
- Undefined: ignored_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package capture_pkg holds:
  - opcode localparams (OP_RESET, OP_ARM, OP_ID, OP_TMASK, OP_TVAL, OP_TCFG, OP_DIV, OP_CNT);
  - the state enum typedef;
  - the byte_swap32 function.
- One natural sub-module, capture_sequencer: the FSM plus delay counter. The top level holds the config register file and opcode decode.

Test Plan:
- Reset, then read outputs -> all config registers 0, state_o = 0, busy = 0, pulses low.
- 0xC0 with command = 0x78563412 -> trig_mask = 0x12345678 one cycle later. Repeat the write while ARMED -> unchanged, ignored_cnt = 1 (STATS_EN).
- Set delay_count = 3, trig_start = 1, arm, trigger_hit at cycle T, ticks on 4 cycles -> POST after T, RD_REQ after the 3rd tick, readout_start pulse of 1 cycle; readout_done -> IDLE.
- trig_start = 0, delay_count = 0, arm -> POST for 1 cycle, then readout_start. capture_en is high for exactly 1 cycle.
- 0x00 issued in POST on the same cycle as sample_tick -> soft_reset pulse, IDLE next cycle, capture_en = 0, config retained.
- Opcode 0x02 in IDLE -> id_req single pulse. Opcode 0x55 -> no change, ignored_cnt increments. 300 unknown commands -> ignored_cnt = 255.
